// File: rtl/muldiv_pkg.sv
// Shared op-code constants and op-class decoding for the HI/LO multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_DIV   = 4'd2,
        OP_MTHI  = 4'd3,
        OP_MTLO  = 4'd4,
        OP_MULTU = 4'd7,
        OP_DIVU  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MOVE
    } op_class_e;

    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return CLS_MUL;
            OP_DIV, OP_DIVU:                                         return CLS_DIV;
            OP_MTHI, OP_MTLO:                                        return CLS_MOVE;
            default:                                                 return CLS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit: ops issue when idle, results land in HI/LO
// on the edge that ends the fixed busy window.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q;

    logic      accept;
    op_class_e issue_cls;
    logic      op_q_is_div;

    assign busy        = (cnt != '0);
    assign accept      = start && !req && !busy;
    assign issue_cls   = op_class(op);
    assign op_q_is_div = (op_class(op_q) == CLS_DIV);

    // Datapath works purely from the latched operands; HI/LO cannot change while busy,
    // so the live registers are the accumulator value seen at acceptance.
    logic                   is_signed;
    logic [2*WIDTH-1:0]     ext_a, ext_b, prod, acc, mul_res;
    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       mag_a, mag_b, divisor, uq, ur, quo, rem;
    logic [WIDTH-1:0]       res_hi, res_lo;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_signed = 1'b0;
        mul_res   = '0;
        res_hi    = hi;
        res_lo    = lo;

        is_signed = (op_q == OP_MULT) || (op_q == OP_MADD) ||
                    (op_q == OP_MSUB) || (op_q == OP_DIV);

        ext_a = is_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b = is_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod  = ext_a * ext_b;
        acc   = {hi, lo};

        case (op_q)
            OP_MADD, OP_MADDU: mul_res = acc + prod;
            OP_MSUB, OP_MSUBU: mul_res = acc - prod;
            default:           mul_res = prod;
        endcase

        // Sign-magnitude divide; MIN_INT / -1 falls out as MIN_INT with zero remainder.
        a_neg   = is_signed && a_q[WIDTH-1];
        b_neg   = is_signed && b_q[WIDTH-1];
        mag_a   = a_neg ? -a_q : a_q;
        mag_b   = b_neg ? -b_q : b_q;
        divisor = (b_q == '0) ? WIDTH'(1) : mag_b;
        uq      = mag_a / divisor;
        ur      = mag_a % divisor;
        quo     = (a_neg ^ b_neg) ? -uq : uq;
        rem     = a_neg ? -ur : ur;

        if (op_q_is_div) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = mul_res[2*WIDTH-1:WIDTH];
            res_lo = mul_res[WIDTH-1:0];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register, operand latches included, is cleared so an aborted op leaves no trace.
            cnt  <= '0;
            op_q <= OP_NOP;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            div0 <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            if (busy) begin
                if (cnt == CNT_ONE) begin
                    cnt  <= '0;
                    done <= 1'b1;
                    if (op_q_is_div && (b_q == '0)) begin
                        div0 <= 1'b1;
                    end else begin
                        hi <= res_hi;
                        lo <= res_lo;
                    end
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
            end else if (accept) begin
                case (issue_cls)
                    CLS_MOVE: begin
                        if (op == OP_MTHI) hi <= a;
                        else               lo <= a;
                    end
                    CLS_MUL, CLS_DIV: begin
                        cnt  <= (issue_cls == CLS_MUL) ? MUL_CNT : DIV_CNT;
                        op_q <= op_e'(op);
                        a_q  <= a;
                        b_q  <= b;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10) with hand-computed results.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic        req;
    logic [31:0] a, b;
    logic        busy, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .req   (req),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .div0  (div0),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an op for one edge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic r);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        req   = r;
        @(negedge clk);
        start = 1'b0;
        req   = 1'b0;
    endtask

    // Expect n more busy cycles, then a one-cycle done with the given results.
    task automatic run_to_done(input string tag, input int n, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input logic exp_div0);
        for (int i = 0; i < n; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " early_done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        check({tag, " busy_end"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " div0"}, 32'(div0), 32'(exp_div0));
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        @(negedge clk);
        check({tag, " done_1cyc"}, 32'(done), 32'd0);
        check({tag, " div0_1cyc"}, 32'(div0), 32'd0);
    endtask

    initial begin
        logic seen_done;
        reset = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        req   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst div0", 32'(div0), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3 = -6
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_to_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);

        // Set HI=0, LO=10, then MADD and MSUBU
        issue(4'd3, 32'd0, 32'd0, 1'b0);
        check("mthi0 busy", 32'(busy), 32'd0);
        check("mthi0 hi", hi, 32'd0);
        issue(4'd4, 32'd10, 32'd0, 1'b0);
        check("mtlo10 lo", lo, 32'd10);
        issue(4'd9, 32'd3, 32'd4, 1'b0);
        run_to_done("madd", 5, 32'd0, 32'd22, 1'b0);
        issue(4'd12, 32'd5, 32'd5, 1'b0);
        run_to_done("msubu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        // Divide by zero keeps HI/LO
        issue(4'd8, 32'd7, 32'd0, 1'b0);
        run_to_done("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);

        // Signed divide: -7 / 2 = -3 rem -1
        issue(4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_to_done("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        // MIN_INT / -1
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_to_done("div_ovf", 10, 32'd0, 32'h8000_0000, 1'b0);

        // DIVU 100 / 7 = 14 rem 2
        issue(4'd8, 32'd100, 32'd7, 1'b0);
        run_to_done("divu", 10, 32'd2, 32'd14, 1'b0);

        // Issue inhibited by req
        issue(4'd1, 32'd9, 32'd9, 1'b1);
        check("req mul busy", 32'(busy), 32'd0);
        issue(4'd4, 32'h99, 32'd0, 1'b1);
        check("req mtlo lo", lo, 32'd14);
        check("req mtlo hi", hi, 32'd2);

        // Undefined op codes do nothing
        issue(4'd5, 32'hDEAD, 32'hBEEF, 1'b0);
        check("nop busy", 32'(busy), 32'd0);
        check("nop lo", lo, 32'd14);

        // MULTU with MTHI and req presented while busy; operands change too
        issue(4'd7, 32'd2, 32'd3, 1'b0);
        start = 1'b1;
        op    = 4'd3;
        a     = 32'h1234;
        b     = 32'h77;
        req   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req   = 1'b0;
        run_to_done("multu_stall", 4, 32'd0, 32'd6, 1'b0);
        check("mthi_busy hi", hi, 32'd0);

        issue(4'd4, 32'h55, 32'd0, 1'b0);
        check("mtlo55 lo", lo, 32'h55);
        check("mtlo55 busy", 32'(busy), 32'd0);

        // Reset 4 cycles into a DIV
        issue(4'd3, 32'hABCD, 32'd0, 1'b0);
        issue(4'd2, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst hi", hi, 32'd0);
        check("midrst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst no_done", 32'(seen_done), 32'd0);
        check("midrst hi_after", hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 SHALL have parameter MUL_LAT, default 5, busy cycles for multiply-class ops; legal range >= 1.
REQ-003 SHALL have parameter DIV_LAT, default 10, busy cycles for divide-class ops; legal range >= 1.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, issue strobe for op.
REQ-007 SHALL have port op, input, 4, operation code.
REQ-008 SHALL have port req, input, 1, exception/interrupt request; inhibits issue when high.
REQ-009 SHALL have ports a and b, input, WIDTH each, operands; a is also the MTHI/MTLO source.
REQ-010 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port div0, output, 1, one-cycle pulse marking a divide-by-zero completion.
REQ-013 SHALL have ports hi and lo, output, WIDTH each, architectural HI/LO registers.

Function
REQ-014 SHALL decode op: 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 7 MULTU, 8 DIVU, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU; all other codes are no-ops and leave state unchanged.
REQ-015 SHALL accept an op only when busy=0, start=1 and req=0; no other condition accepts an op.
REQ-016 SHALL ignore start while busy=1; the pipeline stalls issue.
REQ-017 SHALL write a to HI (MTHI) or LO (MTLO) on the accepting edge; busy stays 0.
REQ-018 SHALL, for a multiply-class op accepted at edge T, load a counter with MUL_LAT and hold busy=1 for exactly MUL_LAT cycles.
REQ-019 SHALL, for a divide-class op, apply the same timing as REQ-018 with DIV_LAT.
REQ-020 SHALL latch the operands and op at acceptance; input changes during busy have no effect.
REQ-021 SHALL write HI/LO on the edge where the counter goes 1 to 0, so new values are visible in the first cycle busy=0.
REQ-022 SHALL assert done in that same cycle, for one cycle only.
REQ-023 SHALL form MULT/MULTU as the signed/unsigned 2*WIDTH product: HI=upper half, LO=lower half.
REQ-024 SHALL compute MADD/MADDU/MSUB/MSUBU as {HI,LO} +/- product, using the HI/LO value at acceptance, wrapping modulo 2^(2*WIDTH).
REQ-025 SHALL set DIV/DIVU results to LO=quotient (truncated toward zero) and HI=remainder (sign of dividend for DIV).
REQ-026 SHALL, for DIV with a=MIN_INT and b=-1, return LO=MIN_INT and HI=0.
REQ-027 SHALL, for a divide with b=0, leave HI/LO unchanged, complete with normal latency, and pulse div0 with done.
REQ-028 SHALL drive hi/lo continuously from the registers; they are not masked during busy.
REQ-029 SHALL ignore req while busy; an in-flight op always completes.

Reset
REQ-030 SHALL, on reset (asynchronous, any time including mid-operation), clear HI, LO, the counter and latched operands to 0, drive busy/done/div0 to 0, and discard the in-flight op with no done pulse.

Structure
REQ-031 SHALL take the op-code constants and op-class helper (mul/div/move) from shared package muldiv_pkg, also used by the decoder.
REQ-032 SHALL be a single module with no sub-module; the arithmetic is computed combinationally from the latched operands and registered at completion.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-033 SHALL cover: MULT a=0xFFFFFFFE, b=3 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done one cycle.
REQ-034 SHALL cover: HI=0, LO=10, MADD a=3, b=4 -> LO=22, HI=0; then MSUBU a=5, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-035 SHALL cover: DIVU a=7, b=0 -> busy 10 cycles, HI/LO unchanged, div0 and done pulse together; DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-036 SHALL cover: start=1 with req=1 -> no busy, HI/LO unchanged; MTHI a=0x1234 while busy -> ignored; MTLO a=0x55 idle -> LO=0x55 next cycle.
REQ-037 SHALL cover: reset asserted 4 cycles into a DIV -> busy=0, HI=LO=0 immediately, no done pulse afterwards.
